gpio_responder: RTL

- Memory-mapped GPIO target on the responder side of the memory controller's data-port stall handshake.
- Decodes requests that fall in its 16-byte window and inserts a configurable number of wait states, asserting `stall` throughout.
- Commits writes to, or returns read data from, its GPIO registers.
- Drives the 4-bit `output_peripherals` pins and samples the 4-bit `input_peripherals` pins through a synchronizer; instantiated by `memory_controller` alongside the ROM/RAM targets.

---
 rtl/gpio_responder_if.sv | 35 +++
 rtl/gpio_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gpio_responder_if.sv
// gpio_responder_if -- request/response bundle between the memory
// controller data port (master) and a memory-mapped target (slave).
//
// Handshake: the master raises mem_read or mem_write with address (and
// input_data for writes). While the target holds stall high, the master
// keeps every request signal stable. The cycle in which stall is low with
// a request outstanding is the completion cycle: output_data is valid
// then, and the master advances at the end of that cycle. mem_write has
// priority over mem_read when both are high.
//
// Signals:
//   address     - byte address of the request
//   input_data  - write data
//   mem_read    - read request
//   mem_write   - write request
//   output_data - read data / pre-write value, valid in the completion cycle
//   stall       - target busy; master must hold the request
interface gpio_responder_if;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] output_data;
  logic        stall;

  modport master (
    output address, input_data, mem_read, mem_write,
    input  output_data, stall
  );

  modport slave (
    input  address, input_data, mem_read, mem_write,
    output output_data, stall
  );
endinterface

// File: rtl/gpio_responder.sv
// gpio_responder -- memory-mapped GPIO target with programmable wait states.
//
// Decodes requests inside a 16-byte window at BASE_ADDRESS, stalls the
// requester for WAIT_STATES extra cycles, then commits a write or returns
// read data. Writes return the register's pre-write value in output_data.
//
// Register map (address[3:2]; address[1:0] ignored):
//   0x0 OUT  : r/w, 4 bits, drives output_peripherals
//   0x4 IN   : read-only, 2-flop synchronized input_peripherals
//   0x8 EDGE : sticky rising-edge flags, write-1-to-clear
//              (only with GPIO_EDGE_CAPTURE_EN defined; otherwise reads 0)
//   0xC      : reserved, reads 0, writes ignored
//
// Optional feature macro: GPIO_EDGE_CAPTURE_EN
//
// Ports:
//   clock              - clock, all state changes on its rising edge
//   reset              - synchronous, active-high
//   bus                - request/response bundle (slave side)
//   input_peripherals  - asynchronous input pins
//   output_peripherals - OUT register value
//   state_dbg          - current FSM state (IDLE=0, WAIT=1, DONE=2)
module gpio_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
  parameter int          WAIT_STATES  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  gpio_responder_if.slave        bus,
  input  logic [3:0]             input_peripherals,
  output logic [3:0]             output_peripherals,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  counter;
  logic [3:0]  out_reg;
  logic [3:0]  sync_meta;
  logic [3:0]  sync_in;
  logic [31:0] data_q;

  logic        sel;
  logic [1:0]  reg_idx;
  logic        commit;
  logic        wr_commit;
  logic [3:0]  rd_val;
  logic        stall_c;

  // Byte-lane bits and upper write-data bits carry no meaning here.
  logic        unused_bits;
  assign unused_bits = ^{bus.address[1:0], bus.input_data[31:4]};

  assign sel     = (bus.mem_read | bus.mem_write) &
                   (bus.address[31:4] == BASE_ADDRESS[31:4]);
  assign reg_idx = bus.address[3:2];

  // The access happens on the last WAIT cycle, and only if the requester
  // is still presenting the request (a dropped sel is a pipeline flush).
  assign commit    = (state == ST_WAIT) && sel && (counter == 4'd0);
  assign wr_commit = commit && bus.mem_write;

  // Two-flop synchronizer for the asynchronous input pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 4'b0;
      sync_in   <= 4'b0;
    end else begin
      sync_meta <= input_peripherals;
      sync_in   <= sync_meta;
    end
  end

`ifdef GPIO_EDGE_CAPTURE_EN
  logic [3:0] sync_prev;
  logic [3:0] edge_flags;
  logic [3:0] edge_set;
  logic [3:0] edge_clr;

  assign edge_set = sync_in & ~sync_prev;
  assign edge_clr = (wr_commit && (reg_idx == REG_EDGE)) ? bus.input_data[3:0] : 4'b0;

  // Clear is applied first so a coincident new edge survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_prev  <= 4'b0;
      edge_flags <= 4'b0;
    end else begin
      sync_prev  <= sync_in;
      edge_flags <= (edge_flags & ~edge_clr) | edge_set;
    end
  end
`endif

  // Register read mux; for writes this is the pre-write value returned.
  always_comb begin
    rd_val = 4'b0;
    case (reg_idx)
      REG_OUT:  rd_val = out_reg;
      REG_IN:   rd_val = sync_in;
`ifdef GPIO_EDGE_CAPTURE_EN
      REG_EDGE: rd_val = edge_flags;
`else
      REG_EDGE: rd_val = 4'b0;
`endif
      default:  rd_val = 4'b0;
    endcase
  end

  always_comb begin
    stall_c = 1'b0;
    case (state)
      ST_IDLE: stall_c = sel;
      ST_WAIT: stall_c = 1'b1;
      ST_DONE: stall_c = 1'b0;
      default: stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= 4'd0;
      out_reg <= 4'b0;
      data_q  <= 32'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel) begin
            counter <= WAIT_LOAD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state <= ST_IDLE;
          end else if (counter == 4'd0) begin
            data_q <= {28'b0, rd_val};
            if (wr_commit && (reg_idx == REG_OUT)) begin
              out_reg <= bus.input_data[3:0];
            end
            state <= ST_DONE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        // The requester advances during DONE, so no new access starts here.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall          = stall_c;
  assign bus.output_data    = data_q;
  assign output_peripherals = out_reg;
  assign state_dbg          = state;

endmodule
